// File: rtl/recovery_transmitter.sv
// Recovery-mode response transmitter: frames a response as LEN0, LEN1, payload
// and an optional CRC-8 PEC byte onto the TTI TX byte stream.
module recovery_transmitter #(
  parameter bit PecEnable = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        res_valid_i,
  output logic        res_ready_o,
  input  logic [15:0] res_len_i,
  input  logic        res_dvalid_i,
  output logic        res_dready_o,
  input  logic [7:0]  res_data_i,
  input  logic        res_dlast_i,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_last_o,
  input  logic        host_nack_i,
  output logic        tx_err_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_PEC
  } state_t;

  localparam state_t EndState = PecEnable ? ST_PEC : ST_IDLE;

  state_t      state_q;
  logic [15:0] len_q;
  logic [15:0] remaining_q;
  logic [7:0]  crc_q;
  logic        err_q;
  logic        tx_hs;
  logic        abort;

  // CRC-8, polynomial x^8+x^2+x+1, MSB first.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  assign abort = (state_q != ST_IDLE) && host_nack_i;
  assign tx_hs = tx_valid_o && tx_ready_i;

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    res_ready_o  = 1'b0;
    res_dready_o = 1'b0;
    tx_valid_o   = 1'b0;
    tx_data_o    = 8'h00;
    tx_last_o    = 1'b0;
    unique case (state_q)
      ST_IDLE: res_ready_o = 1'b1;
      ST_LEN0: begin
        tx_valid_o = 1'b1;
        tx_data_o  = len_q[7:0];
      end
      ST_LEN1: begin
        tx_valid_o = 1'b1;
        tx_data_o  = len_q[15:8];
        tx_last_o  = !PecEnable && (len_q == 16'd0);
      end
      ST_DATA: begin
        tx_valid_o   = res_dvalid_i;
        tx_data_o    = res_data_i;
        res_dready_o = tx_ready_i;
        tx_last_o    = !PecEnable && ((remaining_q == 16'd1) || res_dlast_i);
      end
      ST_PEC: begin
        tx_valid_o = 1'b1;
        tx_data_o  = crc_q;
        tx_last_o  = 1'b1;
      end
      default: ;
    endcase
    // A nack suppresses the byte on offer so the host never sees it accepted.
    if (!rst_ni || abort) begin
      tx_valid_o   = 1'b0;
      res_dready_o = 1'b0;
    end
    if (!rst_ni) res_ready_o = 1'b0;
    tx_last_o = tx_last_o && tx_valid_o;
  end

  assign tx_err_o = err_q && rst_ni;

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      len_q       <= 16'd0;
      remaining_q <= 16'd0;
      crc_q       <= 8'h00;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (abort) begin
        state_q <= ST_IDLE;
        err_q   <= 1'b1;
      end else begin
        unique case (state_q)
          ST_IDLE: if (res_valid_i) begin
            len_q       <= res_len_i;
            remaining_q <= res_len_i;
            crc_q       <= 8'h00;
            state_q     <= ST_LEN0;
          end
          ST_LEN0: if (tx_hs) begin
            crc_q   <= crc8_update(crc_q, tx_data_o);
            state_q <= ST_LEN1;
          end
          ST_LEN1: if (tx_hs) begin
            crc_q   <= crc8_update(crc_q, tx_data_o);
            state_q <= (len_q != 16'd0) ? ST_DATA : EndState;
          end
          ST_DATA: if (tx_hs) begin
            crc_q       <= crc8_update(crc_q, tx_data_o);
            remaining_q <= remaining_q - 16'd1;
            // The byte count ends the frame; dlast only matters when it comes early.
            if (remaining_q == 16'd1) begin
              state_q <= EndState;
            end else if (res_dlast_i) begin
              state_q <= EndState;
              err_q   <= 1'b1;
            end
          end
          ST_PEC: if (tx_hs) state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/recovery_transmitter.md
RECOVERY_TRANSMITTER -- requirements
Module: recovery_transmitter

Interface
REQ-001 SHALL have parameter PecEnable, default 1'b1: when set, a PEC byte is appended to every response.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-003 SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port res_valid_i, input, 1 bit: response header valid.
REQ-005 SHALL have port res_ready_o, output, 1 bit: response header accepted.
REQ-006 SHALL have port res_len_i, input, 16 bits: response payload length in bytes.
REQ-007 SHALL have port res_dvalid_i, input, 1 bit: payload byte valid.
REQ-008 SHALL have port res_dready_o, output, 1 bit: payload byte accepted.
REQ-009 SHALL have port res_data_i, input, 8 bits: payload byte.
REQ-010 SHALL have port res_dlast_i, input, 1 bit: final payload byte marker.
REQ-011 SHALL have port tx_valid_o, output, 1 bit: TTI TX byte valid.
REQ-012 SHALL have port tx_ready_i, input, 1 bit: TTI TX byte accepted.
REQ-013 SHALL have port tx_data_o, output, 8 bits: TX byte.
REQ-014 SHALL have port tx_last_o, output, 1 bit: last byte of the block-read frame.
REQ-015 SHALL have port host_nack_i, input, 1 bit: host terminated the read.
REQ-016 SHALL have port tx_err_o, output, 1 bit: single-cycle pulse on length mismatch or abort.

Function
REQ-017 SHALL implement the FSM states Idle, Len0, Len1, Data and Pec.
REQ-018 SHALL in Idle drive res_ready_o=1 and tx_valid_o=0; on res_valid_i it SHALL register res_len_i into len_q and remaining, clear the CRC to 0x00, and go to Len0 in the next cycle.
REQ-019 SHALL in Len0 drive tx_valid_o=1 and tx_data_o=len_q[7:0]; on tx_ready_i it SHALL go to Len1.
REQ-020 SHALL in Len1 drive tx_data_o=len_q[15:8]; on handshake it SHALL go to Data if len_q≠0, else to Pec (PecEnable=1) or Idle (PecEnable=0).
REQ-021 SHALL in Data pass bytes through combinationally: tx_valid_o=res_dvalid_i, res_dready_o=tx_ready_i, tx_data_o=res_data_i, adding zero latency.
REQ-022 SHALL on each Data handshake decrement remaining; when the handshake occurs with remaining==1 it SHALL go to Pec (PecEnable=1) or Idle (PecEnable=0).
REQ-023 SHALL in Pec drive tx_valid_o=1 and tx_data_o=crc_q; on handshake it SHALL go to Idle.
REQ-024 SHALL assert tx_last_o only together with tx_valid_o on the final frame byte: the Pec byte, or (PecEnable=0) the last data byte or the Len1 byte when len_q==0.
REQ-025 SHALL drive res_ready_o=0 outside Idle and res_dready_o=0 outside Data.
REQ-026 SHALL compute the CRC as CRC-8 (polynomial 0x07, init 0x00, no reflection, no final XOR), updating crc_q over every byte handshaken in Len0, Len1 and Data.
REQ-027 SHALL on res_dlast_i handshaken with remaining>1 treat that byte as final (early end), go to Pec/Idle, and pulse tx_err_o.
REQ-028 SHALL on remaining==1 handshaken without res_dlast_i ignore res_dlast_i; remaining, not res_dlast_i, ends the frame.
REQ-029 SHALL on host_nack_i in any non-Idle state go to Idle in the next cycle, pulse tx_err_o, and emit no further bytes; host_nack_i takes priority over a same-cycle handshake, and that byte is not counted.
REQ-030 SHALL ignore host_nack_i in Idle.
REQ-031 SHALL hold tx_data_o stable while tx_valid_o=1 and tx_ready_i=0 in Len0, Len1 and Pec.
REQ-032 SHALL perform 16-bit length arithmetic, supporting len_q up to 65535 with no wrap of remaining.

Reset
REQ-033 SHALL, while rst_ni=0, force state=Idle, len_q=0, remaining=0 and crc_q=0x00.
REQ-034 SHALL, while rst_ni=0, force tx_valid_o=0, tx_last_o=0, tx_err_o=0 and res_dready_o=0; res_ready_o SHALL read 1 in the first cycle after reset.
REQ-035 SHALL let a reset asserted mid-frame abandon the frame with no further TX bytes.

Verification
REQ-036 SHALL be verified as follows: len=0x0002, payload AA 55, tx_ready_i=1 -> TX 02 00 AA 55 1A, tx_last_o on 0x1A only, tx_err_o=0.
REQ-037 SHALL be verified as follows: len=0 -> TX 00 00 00 (PEC=0x00), tx_last_o on third byte; with PecEnable=0 -> TX 00 00, tx_last_o on second byte.
REQ-038 SHALL be verified as follows: random tx_ready_i back-pressure on a 24-byte response -> byte sequence and PEC identical to the no-stall run, and tx_data_o stable during stalls.
REQ-039 SHALL be verified as follows: len=4, res_dlast_i on second payload byte -> frame 04 00 b0 b1 PEC(04 00 b0 b1), and one tx_err_o pulse.
REQ-040 SHALL be verified as follows: host_nack_i during third payload byte of len=8 -> Idle next cycle, one tx_err_o pulse, and res_ready_o=1; a following len=1 response is emitted correctly with fresh CRC.
REQ-041 SHALL be verified as follows: rst_ni=0 for one cycle in Data -> tx_valid_o=0 next cycle, and the state is Idle.
